// File: rtl/cpu_pkg.sv
// Shared constants and the write-back arbiter state encoding for the
// register-file write-back scheduler.
//   CPU_DATA_WIDTH   : register file data width
//   CPU_ADDR_WIDTH   : register index width
//   CPU_NUM_REGS     : register count (2**CPU_ADDR_WIDTH)
//   CPU_STARVE_LIMIT : ALU denials tolerated before the ALU is forced to win
//   arb_state_e      : PRI_MEM (loads preferred), PRI_ALU (ALU preferred)
package cpu_pkg;

  localparam int CPU_DATA_WIDTH   = 32;
  localparam int CPU_ADDR_WIDTH   = 5;
  localparam int CPU_NUM_REGS     = 2 ** CPU_ADDR_WIDTH;
  localparam int CPU_STARVE_LIMIT = 3;

  typedef enum logic {
    PRI_MEM = 1'b0,
    PRI_ALU = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_arbiter.sv
// Arbiter for the single register-file write port, shared by the ALU and
// load write-back sources. Loads normally win; an ALU that keeps losing is
// promoted for one grant once its starve counter reaches STARVE_LIMIT.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   alu_valid, mem_valid : write-back requests
//   alu_ready, mem_ready : grants (combinational, at most one per cycle)
//
// state   | meaning
// --------+-------------------------------------------------------------
// PRI_MEM | loads have priority; ALU granted only when no load requests
// PRI_ALU | ALU has priority; loads granted only when ALU is idle
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int STARVE_LIMIT = CPU_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic alu_ready,
  output logic mem_ready
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRI_MEM;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    case (state_q)
      PRI_MEM: begin
        mem_ready = mem_valid;
        alu_ready = alu_valid & ~mem_valid;
        // Counter tracks consecutive denials of a waiting ALU request only.
        if (!alu_valid || alu_ready) begin
          cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_MAX) begin
          state_d = PRI_ALU;
        end
      end
      PRI_ALU: begin
        alu_ready = alu_valid;
        mem_ready = mem_valid & ~alu_valid;
        if (alu_ready) begin
          state_d = PRI_MEM;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = PRI_MEM;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler and busy scoreboard for the 32x32 register file.
// Arbitrates ALU and load results onto the single write port (RegWr/Rw/busW,
// one cycle after the grant) and stalls decode on RAW/WAW hazards against
// writes still in flight.
// Ports:
//   iss_valid/iss_rd/iss_ra/iss_rb : decode issue request; iss_stall = hazard
//   alu_valid/alu_rd/alu_data      : ALU write-back request; alu_ready = grant
//   mem_valid/mem_rd/mem_data      : load write-back request; mem_ready = grant
//   RegWr/Rw/busW                  : register file write port
//   busy                           : bit i set while a write to reg i pends
module regfile_wb_sched
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = CPU_DATA_WIDTH,
  parameter int ADDR_WIDTH   = CPU_ADDR_WIDTH,
  parameter int NUM_REGS     = 2 ** ADDR_WIDTH,
  parameter int STARVE_LIMIT = CPU_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] iss_ra,
  input  logic [ADDR_WIDTH-1:0] iss_rb,
  output logic                  iss_stall,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [ADDR_WIDTH-1:0] mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  output logic                  RegWr,
  output logic [ADDR_WIDTH-1:0] Rw,
  output logic [DATA_WIDTH-1:0] busW,
  output logic [NUM_REGS-1:0]   busy
);

  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  regwr_q, regwr_d;
  logic [ADDR_WIDTH-1:0] rw_q, rw_d;
  logic [DATA_WIDTH-1:0] busw_q, busw_d;

  logic                  grant;
  logic                  iss_accept;
  logic [ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  wb_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_wb_arbiter (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_valid(alu_valid),
    .mem_valid(mem_valid),
    .alu_ready(alu_ready),
    .mem_ready(mem_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      regwr_q <= 1'b0;
      rw_q    <= '0;
      busw_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      regwr_q <= regwr_d;
      rw_q    <= rw_d;
      busw_q  <= busw_d;
    end
  end

  always_comb begin
    iss_stall  = iss_valid & (busy_q[iss_ra] | busy_q[iss_rb] | busy_q[iss_rd]);
    iss_accept = iss_valid & ~iss_stall;

    // Grants are mutually exclusive, so a simple select suffices.
    grant   = alu_ready | mem_ready;
    wb_rd   = alu_ready ? alu_rd : mem_rd;
    wb_data = alu_ready ? alu_data : mem_data;

    // r0 grants are acknowledged but never reach the register file.
    regwr_d = grant & (wb_rd != '0);
    rw_d    = grant ? wb_rd : rw_q;
    busw_d  = grant ? wb_data : busw_q;

    // Clear first so a same-edge set of the same index wins.
    busy_d = busy_q;
    if (regwr_q) begin
      busy_d[rw_q] = 1'b0;
    end
    if (iss_accept && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign RegWr = regwr_q;
  assign Rw    = rw_q;
  assign busW  = busw_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_rd = '0, iss_ra = '0, iss_rb = '0;
  logic        iss_stall;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic        RegWr;
  logic [4:0]  Rw;
  logic [31:0] busW;
  logic [31:0] busy;

  regfile_wb_sched dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ra(iss_ra), .iss_rb(iss_rb),
    .iss_stall(iss_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .RegWr(RegWr), .Rw(Rw), .busW(busW), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at the negedge of a cycle in which a grant is expected.
  task automatic push_exp(input logic [4:0] rd, input logic [31:0] d);
    if (rd != 5'd0) exp_q.push_back('{cyc + 1, rd, d});
  endtask

  // Write-port scoreboard: every out-of-reset cycle must match the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        mon_e = exp_q.pop_front();
        errors++;
        $display("FAIL sb_missed: write rd=%0d data=%h never seen (due cycle %0d)",
                 mon_e.rd, mon_e.data, mon_e.cyc);
      end
      checks++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        if (RegWr !== 1'b1 || Rw !== mon_e.rd || busW !== mon_e.data) begin
          errors++;
          $display("FAIL sb_write: got RegWr=%b Rw=%0d busW=%h, want RegWr=1 Rw=%0d busW=%h",
                   RegWr, Rw, busW, mon_e.rd, mon_e.data);
        end
      end else if (RegWr !== 1'b0) begin
        errors++;
        $display("FAIL sb_idle: got RegWr=%b Rw=%0d, want RegWr=0 (cycle %0d)", RegWr, Rw, cyc);
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (busy !== 32'h0 || RegWr !== 1'b0 || Rw !== 5'd0 || busW !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%h RegWr=%b Rw=%0d busW=%h, want all 0",
               busy, RegWr, Rw, busW);
    end
    checks++;
    if (alu_ready !== 1'b0 || mem_ready !== 1'b0 || iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got alu_ready=%b mem_ready=%b iss_stall=%b, want 0 0 0",
               alu_ready, mem_ready, iss_stall);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_raw();
    iss_valid = 1'b1; iss_rd = 5'd5; iss_ra = 5'd1; iss_rb = 5'd2;
    @(negedge clk);
    checks++;
    if (iss_stall !== 1'b0) begin
      errors++; $display("FAIL raw_first_issue: got iss_stall=%b, want 0", iss_stall);
    end
    step();
    iss_rd = 5'd6; iss_ra = 5'd5; iss_rb = 5'd0;
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++;
    if (iss_stall !== 1'b1 || busy !== 32'h0000_0020) begin
      errors++;
      $display("FAIL raw_stall: got iss_stall=%b busy=%h, want 1 00000020", iss_stall, busy);
    end
    checks++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL raw_mem_grant: got mem_ready=%b alu_ready=%b, want 1 0", mem_ready, alu_ready);
    end
    push_exp(5'd5, 32'hDEADBEEF);
    step();
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (Rw !== 5'd5 || busW !== 32'hDEADBEEF || iss_stall !== 1'b1) begin
      errors++;
      $display("FAIL raw_write: got Rw=%0d busW=%h iss_stall=%b, want 5 deadbeef 1",
               Rw, busW, iss_stall);
    end
    step();
    @(negedge clk);
    checks++;
    if (busy !== 32'h0 || iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL raw_release: got busy=%h iss_stall=%b, want 0 0", busy, iss_stall);
    end
    iss_valid = 1'b0;
    step();
  endtask

  task automatic test_collision();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA5A5_0003;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h5A5A_0004;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
      errors++;
      $display("FAIL coll_mem_wins: got mem_ready=%b alu_ready=%b, want 1 0", mem_ready, alu_ready);
    end
    push_exp(5'd4, 32'h5A5A_0004);
    step();
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_ready !== 1'b1 || Rw !== 5'd4) begin
      errors++;
      $display("FAIL coll_alu_next: got alu_ready=%b Rw=%0d, want 1 4", alu_ready, Rw);
    end
    push_exp(5'd3, 32'hA5A5_0003);
    step();
    alu_valid = 1'b0;
    step();
  endtask

  task automatic test_starve();
    int  cnt = 0;
    bit  pri_alu = 1'b0;
    bit  exp_alu;
    alu_valid = 1'b1; alu_rd = 5'd9;  alu_data = 32'hC0DE_0009;
    mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hD00D_000A;
    for (int k = 1; k <= 10; k++) begin
      exp_alu = pri_alu;
      @(negedge clk);
      checks++;
      if (alu_ready !== exp_alu || mem_ready !== !exp_alu) begin
        errors++;
        $display("FAIL starve_cycle%0d: got alu_ready=%b mem_ready=%b, want %b %b",
                 k, alu_ready, mem_ready, exp_alu, !exp_alu);
      end
      if (exp_alu) push_exp(5'd9, 32'hC0DE_0009);
      else         push_exp(5'd10, 32'hD00D_000A);
      if (pri_alu) begin
        pri_alu = 1'b0;
        cnt = 0;
      end else begin
        if (cnt < 3) cnt++;
        if (cnt == 3) pri_alu = 1'b1;
      end
      step();
    end
    alu_valid = 1'b0; mem_valid = 1'b0;
    step();
  endtask

  task automatic test_r0();
    iss_valid = 1'b1; iss_rd = 5'd0; iss_ra = 5'd0; iss_rb = 5'd0;
    @(negedge clk);
    checks++;
    if (iss_stall !== 1'b0) begin
      errors++; $display("FAIL r0_issue: got iss_stall=%b, want 0", iss_stall);
    end
    step();
    iss_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if (busy !== 32'h0 || alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL r0_busy_grant: got busy=%h alu_ready=%b, want 0 1", busy, alu_ready);
    end
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (RegWr !== 1'b0) begin
      errors++; $display("FAIL r0_no_write: got RegWr=%b, want 0", RegWr);
    end
    step();
  endtask

  task automatic test_waw();
    iss_valid = 1'b1; iss_rd = 5'd7; iss_ra = 5'd1; iss_rb = 5'd1;
    @(negedge clk);
    checks++;
    if (iss_stall !== 1'b0) begin
      errors++; $display("FAIL waw_first_issue: got iss_stall=%b, want 0", iss_stall);
    end
    step();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hFEED_0007;
    @(negedge clk);
    checks++;
    if (busy !== 32'h0000_0080 || iss_stall !== 1'b1 || alu_ready !== 1'b1) begin
      errors++;
      $display("FAIL waw_stall: got busy=%h iss_stall=%b alu_ready=%b, want 00000080 1 1",
               busy, iss_stall, alu_ready);
    end
    push_exp(5'd7, 32'hFEED_0007);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (Rw !== 5'd7 || iss_stall !== 1'b1) begin
      errors++;
      $display("FAIL waw_write_cycle: got Rw=%0d iss_stall=%b, want 7 1", Rw, iss_stall);
    end
    step();
    @(negedge clk);
    checks++;
    if (iss_stall !== 1'b0 || busy !== 32'h0) begin
      errors++;
      $display("FAIL waw_release: got iss_stall=%b busy=%h, want 0 0", iss_stall, busy);
    end
    iss_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    iss_valid = 1'b1; iss_rd = 5'd5; iss_ra = 5'd0; iss_rb = 5'd0;
    step();
    iss_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd5; mem_data = 32'hF00D_0005;
    @(negedge clk);
    checks++;
    if (busy !== 32'h0000_0020 || mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got busy=%h mem_ready=%b, want 00000020 1", busy, mem_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 32'h0 || RegWr !== 1'b0 || Rw !== 5'd0 || busW !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_clear: got busy=%h RegWr=%b Rw=%0d busW=%h, want all 0",
               busy, RegWr, Rw, busW);
    end
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_regrant: got mem_ready=%b, want 1", mem_ready);
    end
    push_exp(5'd5, 32'hF00D_0005);
    step();
    mem_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (Rw !== 5'd5 || busW !== 32'hF00D_0005) begin
      errors++;
      $display("FAIL rstmid_write: got Rw=%0d busW=%h, want 5 f00d0005", Rw, busW);
    end
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_raw();
    test_collision();
    test_starve();
    test_r0();
    test_waw();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending writes, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
Write-back scheduler and scoreboard for the 32x32 register file.
- Shares the register file's single write port (RegWr/Rw/busW) between two write-back sources: ALU results and memory-load results.
- Keeps a per-register busy scoreboard so decode stalls on RAW and WAW hazards against writes still in flight.
- Sits between decode/execute/memory stages and the register file; drives the register file's write inputs directly.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 5, register index width
NUM_REGS, 32, number of registers (2**ADDR_WIDTH)
STARVE_LIMIT, 3, consecutive ALU-denied cycles before ALU is forced to win

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
iss_valid  input  1  decode presents an instruction that will write iss_rd
iss_rd  input  ADDR_WIDTH  destination register of issuing instruction
iss_ra  input  ADDR_WIDTH  source register A of issuing instruction
iss_rb  input  ADDR_WIDTH  source register B of issuing instruction
iss_stall  output  1  issue blocked this cycle (hazard)
alu_valid  input  1  ALU write-back request
alu_rd  input  ADDR_WIDTH  ALU destination
alu_data  input  DATA_WIDTH  ALU result
alu_ready  output  1  ALU request granted this cycle
mem_valid  input  1  load write-back request
mem_rd  input  ADDR_WIDTH  load destination
mem_data  input  DATA_WIDTH  load data
mem_ready  output  1  load request granted this cycle
RegWr  output  1  register file write enable
Rw  output  ADDR_WIDTH  register file write index
busW  output  DATA_WIDTH  register file write data
busy  output  NUM_REGS  scoreboard, bit i = write to register i outstanding

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, RegWr=0, Rw=0, busW=0.
  - Arbiter state PRI_MEM; starve counter 0.
  - In-flight grants are discarded. Requesters re-present after reset.
- Scoreboard:
  - iss_stall = iss_valid & (busy[iss_ra] | busy[iss_rb] | busy[iss_rd]). Combinational.
  - Issue is accepted when iss_valid & !iss_stall. At that edge busy[iss_rd] is set, unless iss_rd==0.
  - busy[0] is constant 0.
  - busy[Rw] clears at the edge that ends a cycle with RegWr=1. This is the same edge at which the register file commits the write, so the next-cycle read sees the new value.
  - If set and clear of the same index fall on one edge, set wins.
- Handshake:
  - valid/rd/data must hold stable until ready=1.
  - ready is combinational from valid and arbiter state. valid must not depend on ready.
  - Transfer occurs on any cycle with valid & ready.
- Arbiter FSM:
  - PRI_MEM:
    - mem_valid wins; ALU wins only when mem_valid=0.
    - Counter increments when alu_valid & !alu_ready, saturating at STARVE_LIMIT. It clears on an ALU grant or when alu_valid=0.
    - When the counter reaches STARVE_LIMIT at an edge -> PRI_ALU.
  - PRI_ALU: alu_valid wins; mem waits. On ALU grant -> PRI_MEM and counter=0. If alu_valid=0, mem may be granted and the state holds.
  - At most one grant per cycle.
- Write port:
  - Granted rd/data are registered onto Rw/busW. RegWr=1 on the cycle after the grant (latency 1).
  - RegWr=0 on cycles following no grant. Rw/busW hold their last values.
  - A grant with rd==0 is acknowledged but produces RegWr=0.
- Widths: no arithmetic except the counter, sized clog2(STARVE_LIMIT+1).

Decomposition:
- Shared package cpu_pkg:
  - DATA_WIDTH/ADDR_WIDTH/NUM_REGS constants.
  - Arbiter state encoding (PRI_MEM=0, PRI_ALU=1).
- One natural sub-module, wb_arbiter: FSM, starve counter and grant logic.
- Scoreboard and write-port registers stay in the top module.

Test Plan:
- Reset mid-run: assert rst_n=0 while busy[5]=1 and a grant is pending -> immediately busy=0, RegWr=0, Rw=0, busW=0; after release, first mem grant behaves normally.
- RAW stall: issue rd=5 accepted. Next cycle issue ra=5 -> iss_stall=1. mem grant rd=5, data=0xDEADBEEF -> next cycle RegWr=1, Rw=5, busW=0xDEADBEEF. Following cycle busy[5]=0 and iss_stall=0.
- Collision: alu_valid and mem_valid both high, rd 3 and 4 -> mem_ready=1, alu_ready=0. Next cycle Rw=4; ALU granted once mem_valid drops.
- Starvation: mem_valid held high 10 cycles, alu_valid high -> alu_ready=1 on cycle 4 (after 3 denials). mem regains priority cycle 5. Pattern repeats every 4 cycles.
- r0 handling: issue rd=0 -> busy stays 0. alu grant rd=0, data=0x1234 -> alu_ready=1, RegWr stays 0.
- WAW: busy[7]=1, issue rd=7 with ra=rb=1 -> iss_stall=1 until the cycle after RegWr with Rw=7.
